normalizer: RTL and testbench

//   Multi-cycle left-normalizer: the inverse of the fixed-amount shift unit.

---
 rtl/normalizer.sv | 86 ++++++++
 tb/tb_normalizer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/normalizer.sv
// Multi-cycle left normalizer: shifts an operand left one bit per cycle until
// it is normalized (unsigned or two's-complement) and reports the shift count.
module normalizer #(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   work;
    logic               mode;
    logic [CNT_W-1:0]   count;
    logic               zero;
    logic               is_zero;
    logic               term;

    // Zero never normalizes, so it is detected explicitly to bound the shift count.
    assign is_zero = (work == '0);
    assign term    = is_zero | (mode ? (work[WIDTH-1] ^ work[WIDTH-2]) : work[WIDTH-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SHIFT;
            SHIFT:   if (term)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work  <= '0;
            mode  <= 1'b0;
            count <= '0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    work  <= in_data;
                    mode  <= signed_mode;
                    count <= '0;
                    zero  <= 1'b0;
                end
                SHIFT: begin
                    if (is_zero) begin
                        zero <= 1'b1;
                    end else if (!term) begin
                        work  <= {work[WIDTH-2:0], 1'b0};
                        count <= count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = work;
    assign out_count = count;
    assign out_zero  = zero;

endmodule

// File: tb/tb_normalizer.sv
// Randomized self-checking bench for normalizer against a leading-bit-count
// reference model.
module tb_normalizer;
    localparam int WIDTH = 16;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             signed_mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_zero;

    int n_chk = 0;
    int n_err = 0;

    normalizer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Count = distance from the top to the highest significant bit.
    function automatic void ref_norm(input logic [WIDTH-1:0] x, input bit m,
                                     output logic [WIDTH-1:0] d, output int c, output bit z);
        int hi;
        z  = (x == '0);
        c  = 0;
        hi = -1;
        if (!z) begin
            if (!m) begin
                for (int i = 0; i < WIDTH; i++) if (x[i]) hi = i;
                c = WIDTH - 1 - hi;
            end else begin
                for (int i = 0; i < WIDTH - 1; i++) if (x[i] != x[WIDTH-1]) hi = i;
                c = WIDTH - 2 - hi;
            end
        end
        d = x << c;
    endfunction

    task automatic accept(input logic [WIDTH-1:0] d, input bit m);
        @(negedge clk);
        chk("in_ready_before_accept", in_ready, 1);
        in_valid    = 1'b1;
        in_data     = d;
        signed_mode = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic op(input logic [WIDTH-1:0] d, input bit m, input int hold);
        logic [WIDTH-1:0] ed, sd;
        int ec, lat;
        bit ez;
        logic [CNT_W-1:0] sc;
        logic sz;
        ref_norm(d, m, ed, ec, ez);
        out_ready = 1'b0;
        accept(d, m);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, ec + 1);
        chk("out_data", out_data, ed);
        chk("out_count", out_count, ec);
        chk("out_zero", out_zero, ez);
        sd = out_data; sc = out_count; sz = out_zero;
        for (int k = 0; k < hold; k++) begin
            in_valid = k[0];
            in_data  = 16'h0001;
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_ready", in_ready, 0);
            chk("bp_stable", {out_data, 11'(out_count), out_zero}, {sd, 11'(sc), sz});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);
    endtask

    initial begin
        logic [WIDTH-1:0] r;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_data", out_data, 0);
        chk("rst_count", out_count, 0);
        chk("rst_zero", out_zero, 0);
        @(negedge clk);
        reset = 1'b0;

        op(16'h0001, 1'b0, 0);
        op(16'h8000, 1'b0, 0);
        op(16'h0003, 1'b1, 0);
        op(16'hFFFF, 1'b1, 0);
        op(16'hC000, 1'b1, 0);
        op(16'h0000, 1'b0, 0);
        op(16'h0000, 1'b1, 0);
        op(16'h4000, 1'b1, 10);
        op(16'h1234, 1'b0, 0);

        // Abort mid-shift: five shifts applied, then reset.
        accept(16'h0001, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_count", out_count, 5);
        reset = 1'b1;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_count", out_count, 0);
        chk("abort_data", out_data, 0);
        @(negedge clk);
        reset = 1'b0;
        op(16'h0100, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            r = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: r = r >> $urandom_range(0, 15);
                1: r = $signed(r) >>> $urandom_range(0, 15);
                default: ;
            endcase
            op(r, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
